vec_wb_sequencer: RTL

VEC_WB_SEQUENCER -- requirements
Module: vec_wb_sequencer

---
 rtl/vec_pkg.sv | 15 +
 rtl/vec_wb_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vec_pkg.sv
// Shared vector writeback definitions: lane count, register-file address width and
// sequencer state encoding, reused by EXE and decode.
package vec_pkg;

   localparam int unsigned VEC_LANES = 8;
   localparam int unsigned VEC_AW    = 5;
   localparam int unsigned DATA_W    = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWrite = 2'd1,
      StFin   = 2'd2
   } seq_state_e;

endpackage

// File: rtl/vec_wb_sequencer.sv
// Serialises an EXE vector result bundle into one register-file write per cycle,
// starting at wr_base_addr and wrapping modulo the register-file size.
module vec_wb_sequencer
   import vec_pkg::*;
#(
   parameter int unsigned LANES = VEC_LANES,
   parameter int unsigned AW    = VEC_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AW-1:0]     wr_base_addr,
   input  logic [31:0]       vlen,
   input  logic [DATA_W-1:0] alu_result_v0,
   input  logic [DATA_W-1:0] alu_result_v1,
   input  logic [DATA_W-1:0] alu_result_v2,
   input  logic [DATA_W-1:0] alu_result_v3,
   input  logic [DATA_W-1:0] alu_result_v4,
   input  logic [DATA_W-1:0] alu_result_v5,
   input  logic [DATA_W-1:0] alu_result_v6,
   input  logic [DATA_W-1:0] alu_result_v7,
   input  logic              wb_hold,
   output logic              rf_we,
   output logic [AW-1:0]     rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [4:0]        cnt,
   output logic              busy,
   output logic              done
);

   localparam int unsigned LEN_W = 4;

   seq_state_e        state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [LEN_W-1:0]  len_q;
   logic [AW-1:0]     base_q;
   logic [DATA_W-1:0] lane_q [VEC_LANES];

   logic [LEN_W-1:0]  eff_len;
   logic              accept;
   logic              last_elem;
   logic [DATA_W-1:0] lane_sel;

   // Full-width compare so any vlen above LANES clamps instead of aliasing.
   assign eff_len   = (vlen > 32'(LANES)) ? LEN_W'(LANES) : vlen[LEN_W-1:0];
   assign accept    = in_valid && (state_q == StIdle);
   assign last_elem = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

   always_comb begin
      lane_sel = '0;
      unique case (idx_q)
         3'd0: lane_sel = lane_q[0];
         3'd1: lane_sel = lane_q[1];
         3'd2: lane_sel = lane_q[2];
         3'd3: lane_sel = lane_q[3];
         3'd4: lane_sel = lane_q[4];
         3'd5: lane_sel = lane_q[5];
         3'd6: lane_sel = lane_q[6];
         3'd7: lane_sel = lane_q[7];
         default: lane_sel = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         len_q   <= '0;
         base_q  <= '0;
         lane_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (accept) begin
            len_q     <= eff_len;
            base_q    <= wr_base_addr;
            lane_q[0] <= alu_result_v0;
            lane_q[1] <= alu_result_v1;
            lane_q[2] <= alu_result_v2;
            lane_q[3] <= alu_result_v3;
            lane_q[4] <= alu_result_v4;
            lane_q[5] <= alu_result_v5;
            lane_q[6] <= alu_result_v6;
            lane_q[7] <= alu_result_v7;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      in_ready = 1'b0;
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      cnt      = '0;
      done     = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               idx_d   = '0;
               state_d = (eff_len == '0) ? StFin : StWrite;
            end
         end
         StWrite: begin
            cnt = 5'(idx_q) + 5'd1;
            if (!wb_hold) begin
               rf_we    = 1'b1;
               rf_waddr = base_q + AW'(idx_q);
               rf_wdata = lane_sel;
               if (last_elem) begin
                  idx_d   = '0;
                  state_d = StFin;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy = (state_q != StIdle);

endmodule
